// File: rtl/spi_frame_pkg.sv
// Shared constants, FSM state type and helpers for the SPI frame transmitter.
package spi_frame_pkg;

   localparam int unsigned FRAME_BITS = 88;

   localparam logic [7:0] OP_COEF = 8'h00;
   localparam logic [7:0] OP_RUN  = 8'hff;

   typedef enum logic [2:0] {
      StIdle,
      StWaitTgt,
      StSetup,
      StShift,
      StHold,
      StGap
   } state_t;

   // Chip select is low for the whole frame window, including setup and hold.
   function automatic logic cs_active(input state_t s);
      return (s == StSetup) || (s == StShift) || (s == StHold);
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer and SPI clock register for spi_frame_tx.
module spi_sclk_gen #(
   parameter int unsigned HALF = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run_i,     // timer runs while high, held at zero otherwise
   input  logic toggle_i,  // flip the SPI clock at each phase end
   output logic tick_o,    // last cycle of the current half period
   output logic sclk_o
);

   localparam int unsigned CntW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sclk_q, sclk_d;

   assign tick_o = run_i && (cnt_q == CntW'(HALF - 1));
   assign sclk_o = sclk_q;

   // Next state: timer reloads on every phase end; clock forced low when idle.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      sclk_d = sclk_q;
      if (!run_i || tick_o) begin
         cnt_d = '0;
      end
      if (!run_i) begin
         sclk_d = 1'b0;
      end else if (tick_o && toggle_i) begin
         sclk_d = ~sclk_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_frame_tx.sv
// Host-side SPI master: sends one 88-bit command frame (opcode + payload), mode 0,
// MSB first. RUN frames wait for the target's ready line and never reuse a stale one.
module spi_frame_tx
   import spi_frame_pkg::*;
#(
   parameter int unsigned HALF        = 4,
   parameter int unsigned GAP         = 8,
   parameter int unsigned TGT_TIMEOUT = 4096
) (
   input  logic        clk_sys,
   input  logic        rstb,
   input  logic        valid_in,
   input  logic [7:0]  opcode_in,
   input  logic [79:0] data_in,
   output logic        ready_out,
   input  logic        target_ready,
   output logic        clk_mosi,
   output logic        cs,
   output logic        spi_mosi,
   output logic        done,
   output logic        err
);

   localparam int unsigned TmoW = (TGT_TIMEOUT > 1) ? $clog2(TGT_TIMEOUT) : 1;
   localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
   logic [6:0]              bit_cnt_q, bit_cnt_d;
   logic [TmoW-1:0]         tmo_cnt_q, tmo_cnt_d;
   logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;
   logic                    full_q, full_d;      // frame latched, not yet started
   logic                    is_run_q, is_run_d;
   logic                    pending_q, pending_d;
   logic                    cs_q, cs_d;
   logic                    mosi_q, mosi_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    tr_s1_q, tr_s2_q;
   logic                    sync_ready;
   logic                    tick;

   assign sync_ready = tr_s2_q;
   assign ready_out  = (state_q == StIdle) && !full_q;
   assign cs         = cs_q;
   assign spi_mosi   = mosi_q;
   assign done       = done_q;
   assign err        = err_q;

   spi_sclk_gen #(
      .HALF(HALF)
   ) u_sclk (
      .clk_i   (clk_sys),
      .rst_ni  (rstb),
      .run_i   (cs_active(state_q)),
      .toggle_i(state_q == StShift),
      .tick_o  (tick),
      .sclk_o  (clk_mosi)
   );

   // Next state, frame shifting, wait/gap counters and registered outputs.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      tmo_cnt_d = '0;
      gap_cnt_d = '0;
      full_d    = full_q;
      is_run_d  = is_run_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (full_q) begin
               full_d  = 1'b0;
               state_d = is_run_q ? StWaitTgt : StSetup;
            end else if (valid_in) begin
               full_d   = 1'b1;
               sreg_d   = {opcode_in, data_in};
               is_run_d = (opcode_in == OP_RUN);
            end
         end
         StWaitTgt: begin
            if (sync_ready && !pending_q) begin
               state_d = StSetup;
            end else if (tmo_cnt_q == TmoW'(TGT_TIMEOUT - 1)) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         StSetup: begin
            bit_cnt_d = '0;
            if (tick) begin
               state_d = StShift;
            end
         end
         StShift: begin
            // Phase end with clock high is a falling edge: move to the next bit.
            if (tick && clk_mosi) begin
               if (bit_cnt_q == 7'(FRAME_BITS - 1)) begin
                  state_d = StHold;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  sreg_d    = {sreg_q[FRAME_BITS-2:0], 1'b0};
               end
            end
         end
         StHold: begin
            if (tick) begin
               state_d = StGap;
            end
         end
         StGap: begin
            if (gap_cnt_q == GapW'(GAP - 1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // A low observation clears pending even on the cycle it would be set.
      pending_d = (pending_q || (state_q == StHold && tick && is_run_q)) && sync_ready;

      cs_d   = !cs_active(state_d);
      mosi_d = ((state_d == StSetup) || (state_d == StShift)) ? sreg_d[FRAME_BITS-1] : 1'b0;
   end

   // State and output registers; reset acts immediately, even mid-frame.
   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
         state_q   <= StIdle;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         tmo_cnt_q <= '0;
         gap_cnt_q <= '0;
         full_q    <= 1'b0;
         is_run_q  <= 1'b0;
         pending_q <= 1'b0;
         cs_q      <= 1'b1;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         full_q    <= full_d;
         is_run_q  <= is_run_d;
         pending_q <= pending_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Two-flop synchroniser for the asynchronous target ready line.
   always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
         tr_s1_q <= 1'b0;
         tr_s2_q <= 1'b0;
      end else begin
         tr_s1_q <= target_ready;
         tr_s2_q <= tr_s1_q;
      end
   end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: one instance with default timeout, one with a
// short timeout for the timeout and stale-ready scenarios.
module tb_spi_frame_tx;
   import spi_frame_pkg::*;

   logic        clk_sys = 1'b0;
   logic        rstb;
   logic        valid_in;
   logic [7:0]  opcode_in;
   logic [79:0] data_in;
   logic        target_ready;
   logic        sel;

   logic a_ready, a_clk, a_cs, a_mosi, a_done, a_err;
   logic b_ready, b_clk, b_cs, b_mosi, b_done, b_err;
   logic o_ready, o_clk, o_cs, o_mosi, o_done, o_err;

   int cyc = 0;
   int t0;
   int n_tests = 0;
   int n_fail  = 0;

   int w_rises, w_first_rise, w_cs_fall, w_cs_falls, w_ready;
   int w_done_cnt, w_done_first, w_done_last, w_err_cnt, w_err_first;
   int w_bad, w_toggles, w_both;
   logic [87:0] w_bits;

   localparam logic [79:0] DCoef = 80'h0123_4567_89AB_CDEF_1357;
   localparam logic [79:0] DRun  = 80'hDEAD_BEEF_0000_FFFF_A5C3;
   localparam logic [79:0] DB2b  = 80'h1111_2222_3333_4444_5555;
   localparam logic [79:0] DNew  = 80'hFEDC_BA98_7654_3210_0F0F;

   spi_frame_tx #(.HALF(4), .GAP(8), .TGT_TIMEOUT(4096)) u_dut (
      .clk_sys(clk_sys), .rstb(rstb), .valid_in(valid_in), .opcode_in(opcode_in),
      .data_in(data_in), .ready_out(a_ready), .target_ready(target_ready),
      .clk_mosi(a_clk), .cs(a_cs), .spi_mosi(a_mosi), .done(a_done), .err(a_err)
   );

   spi_frame_tx #(.HALF(4), .GAP(8), .TGT_TIMEOUT(64)) u_dut_tmo (
      .clk_sys(clk_sys), .rstb(rstb), .valid_in(valid_in), .opcode_in(opcode_in),
      .data_in(data_in), .ready_out(b_ready), .target_ready(target_ready),
      .clk_mosi(b_clk), .cs(b_cs), .spi_mosi(b_mosi), .done(b_done), .err(b_err)
   );

   assign o_ready = sel ? b_ready : a_ready;
   assign o_clk   = sel ? b_clk   : a_clk;
   assign o_cs    = sel ? b_cs    : a_cs;
   assign o_mosi  = sel ? b_mosi  : a_mosi;
   assign o_done  = sel ? b_done  : a_done;
   assign o_err   = sel ? b_err   : a_err;

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      #2 rstb = 1'b0;
      repeat (3) @(posedge clk_sys);
      #2 rstb = 1'b1;
      repeat (3) tick();
   endtask

   // Present a frame for one edge; t0 becomes the accepting edge's cycle number.
   task automatic send(input logic [7:0] op, input logic [79:0] d, input logic hold);
      valid_in  = 1'b1;
      opcode_in = op;
      data_in   = d;
      tick();
      t0 = cyc;
      if (!hold) valid_in = 1'b0;
   endtask

   // Sample outputs for n cycles after t0, optionally raising or pulsing target_ready.
   task automatic watch(input int n, input int tr_rise_at, input logic pulse_low);
      logic prev_clk, prev_cs;
      int   rel, low_until;
      w_rises = 0; w_first_rise = -1; w_cs_fall = -1; w_cs_falls = 0; w_ready = -1;
      w_done_cnt = 0; w_done_first = -1; w_done_last = -1; w_err_cnt = 0; w_err_first = -1;
      w_bad = 0; w_toggles = 0; w_both = 0; w_bits = '0;
      prev_clk = o_clk; prev_cs = o_cs; low_until = -1;
      for (int i = 0; i < n; i++) begin
         tick();
         rel = cyc - t0;
         if (o_clk !== prev_clk) begin
            w_toggles++;
            if (o_cs) w_bad++;
            if (o_clk) begin
               w_rises++;
               w_bits = {w_bits[86:0], o_mosi};
               if (w_first_rise < 0) w_first_rise = rel;
            end
         end
         if (!o_cs && prev_cs) begin
            w_cs_falls++;
            if (w_cs_fall < 0) w_cs_fall = rel;
         end
         if (o_cs && !prev_cs && pulse_low && low_until < 0) begin
            target_ready = 1'b0;
            low_until    = rel + 4;
         end
         if (rel == low_until) target_ready = 1'b1;
         if (rel == tr_rise_at) target_ready = 1'b1;
         if (o_ready && w_ready < 0) w_ready = rel;
         if (o_done) begin
            w_done_cnt++;
            w_done_last = rel;
            if (w_done_first < 0) w_done_first = rel;
         end
         if (o_err) begin
            w_err_cnt++;
            if (w_err_first < 0) w_err_first = rel;
         end
         if (o_done && o_err) w_both++;
         prev_clk = o_clk;
         prev_cs  = o_cs;
      end
   endtask

   initial begin
      rstb = 1'b1; valid_in = 1'b0; opcode_in = '0; data_in = '0;
      target_ready = 1'b0; sel = 1'b0;

      // Asynchronous reset, checked before the first clock edge.
      #1 rstb = 1'b0;
      #2;
      check("rst_ready", 88'(o_ready), 88'(1));
      check("rst_cs",    88'(o_cs),    88'(1));
      check("rst_clk",   88'(o_clk),   88'(0));
      check("rst_mosi",  88'(o_mosi),  88'(0));
      check("rst_done",  88'(o_done),  88'(0));
      check("rst_err",   88'(o_err),   88'(0));
      repeat (3) @(posedge clk_sys);
      #2 rstb = 1'b1;
      tick();
      t0 = cyc;
      watch(1000, -1, 1'b0);
      check("idle_toggles", 88'(w_toggles),  88'(0));
      check("idle_done",    88'(w_done_cnt), 88'(0));
      check("idle_cs",      88'(w_cs_falls), 88'(0));

      // Coefficient frame with default timing.
      send(OP_COEF, DCoef, 1'b0);
      watch(730, -1, 1'b0);
      check("coef_first_rise", 88'(w_first_rise), 88'(9));
      check("coef_rises",      88'(w_rises),      88'(88));
      check("coef_bits",       w_bits,            {8'h00, DCoef});
      check("coef_done_cnt",   88'(w_done_cnt),   88'(1));
      check("coef_done_cyc",   88'(w_done_first), 88'(721));
      check("coef_ready_cyc",  88'(w_ready),      88'(721));
      check("coef_err",        88'(w_err_cnt),    88'(0));
      check("coef_cs_clk",     88'(w_bad),        88'(0));

      // RUN frame gated on target_ready rising at cycle 100.
      target_ready = 1'b0;
      do_reset();
      send(OP_RUN, DRun, 1'b0);
      watch(850, 100, 1'b0);
      check("run_cs_fall",    88'(w_cs_fall),    88'(103));
      check("run_first_rise", 88'(w_first_rise), 88'(111));
      check("run_bits",       w_bits,            {8'hff, DRun});
      check("run_done_cyc",   88'(w_done_first), 88'(823));
      check("run_ready_cyc",  88'(w_ready),      88'(823));
      check("run_cs_clk",     88'(w_bad),        88'(0));

      // RUN frame timing out (short-timeout instance).
      sel = 1'b1;
      target_ready = 1'b0;
      do_reset();
      send(OP_RUN, DRun, 1'b0);
      watch(200, -1, 1'b0);
      check("tmo_err_cyc",   88'(w_err_first), 88'(65));
      check("tmo_err_cnt",   88'(w_err_cnt),   88'(1));
      check("tmo_ready_cyc", 88'(w_ready),     88'(65));
      check("tmo_cs",        88'(w_cs_falls),  88'(0));
      check("tmo_done",      88'(w_done_cnt),  88'(0));

      // Back-to-back RUN frames on a ready line that never drops.
      target_ready = 1'b1;
      do_reset();
      send(OP_RUN, DB2b, 1'b1);
      watch(800, -1, 1'b0);
      valid_in = 1'b0;
      check("stale_cs_falls", 88'(w_cs_falls),   88'(1));
      check("stale_done_cnt", 88'(w_done_cnt),   88'(1));
      check("stale_done_cyc", 88'(w_done_first), 88'(722));
      check("stale_err_cnt",  88'(w_err_cnt),    88'(1));
      check("stale_err_cyc",  88'(w_err_first),  88'(788));
      check("stale_both",     88'(w_both),       88'(0));

      // Same, but ready pulses low for 4 cycles after frame 1.
      target_ready = 1'b1;
      do_reset();
      send(OP_RUN, DB2b, 1'b1);
      watch(1460, -1, 1'b1);
      valid_in = 1'b0;
      check("pulse_cs_fall",   88'(w_cs_fall),   88'(2));
      check("pulse_cs_falls",  88'(w_cs_falls),  88'(2));
      check("pulse_done_cnt",  88'(w_done_cnt),  88'(2));
      check("pulse_done_last", 88'(w_done_last), 88'(1445));
      check("pulse_err_cnt",   88'(w_err_cnt),   88'(0));
      check("pulse_rises",     88'(w_rises),     88'(176));
      check("pulse_bits",      w_bits,           {8'hff, DB2b});

      // Reset in the middle of bit 40, then a fresh frame.
      sel = 1'b0;
      do_reset();
      send(OP_COEF, DCoef, 1'b0);
      watch(331, -1, 1'b0);
      check("mid_rises", 88'(w_rises), 88'(41));
      check("mid_clk",   88'(o_clk),   88'(1));
      check("mid_cs",    88'(o_cs),    88'(0));
      #2 rstb = 1'b0;
      #1;
      check("mid_rst_cs",    88'(o_cs),    88'(1));
      check("mid_rst_clk",   88'(o_clk),   88'(0));
      check("mid_rst_mosi",  88'(o_mosi),  88'(0));
      check("mid_rst_ready", 88'(o_ready), 88'(1));
      repeat (2) @(posedge clk_sys);
      #2 rstb = 1'b1;
      tick();
      send(8'h5A, DNew, 1'b0);
      watch(730, -1, 1'b0);
      check("new_first_rise", 88'(w_first_rise), 88'(9));
      check("new_bits",       w_bits,            {8'h5A, DNew});
      check("new_done_cyc",   88'(w_done_first), 88'(721));
      check("new_rises",      88'(w_rises),      88'(88));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Host-side SPI master that serialises one command frame (8-bit opcode + 80-bit payload) onto clk_mosi/cs/spi_mosi.
- Frame format is the one the motor-control FPGA's SPI receiver consumes.
- Used as the ECU/test-host emulator and as the stimulus driver in system-level benches.
- For RUN frames (opcode 8'hff), gates transmission on the target's ready line and never overruns an in-progress FOC cycle.

Parameters:
- HALF, 4: clk_sys cycles per SPI half period; legal range 2..255.
- GAP, 8: clk_sys cycles cs stays inactive after a frame; minimum 1.
- TGT_TIMEOUT, 4096: maximum clk_sys cycles spent waiting for target_ready before a RUN frame is dropped.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rstb  in  1  asynchronous active-low reset.
- valid_in  in  1  frame request.
- opcode_in  in  8  frame opcode.
- data_in  in  80  payload; [79:64] word4 … [15:0] word0.
- ready_out  out  1  block can accept a frame.
- target_ready  in  1  target's ready line; asynchronous, 2-FF synchronised.
- clk_mosi  out  1  SPI clock, mode 0, idles low.
- cs  out  1  chip select, active low, idles high.
- spi_mosi  out  1  serial data; changes while clk_mosi is low.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse when a RUN frame is dropped on timeout.

Behaviour:
- Reset: ready_out=1, cs=1, clk_mosi=0, spi_mosi=0, done=0, err=0, pending=0, FSM=IDLE. Applies asynchronously, including mid-frame.
- Accept: valid_in && ready_out at edge t.
  - {opcode_in, data_in} latched into an 88-bit shift register.
  - ready_out=0 from t+1.
  - valid_in while ready_out=0 is ignored; it is not queued.
- FSM states: IDLE, WAIT_TGT, SETUP, SHIFT, HOLD, GAP.
- IDLE -> WAIT_TGT if the latched opcode is 8'hff; otherwise IDLE -> SETUP.
- WAIT_TGT:
  - Proceeds to SETUP when sync_ready==1 && pending==0.
  - The timeout counter is cleared on entry. Reaching TGT_TIMEOUT -> err pulse, ready_out=1 on the same cycle, back to IDLE, no cs activity.
  - With pending=0 and target_ready already high, cs asserts at the latest 3 cycles after entry. Otherwise cs asserts 3 cycles after a target_ready rise.
- SETUP (HALF cycles):
  - cs=0, clk_mosi=0, spi_mosi=frame bit 87.
- SHIFT, 88 bits, MSB first: opcode[7] first, data[0] last. Per bit:
  - Low phase of HALF cycles.
  - clk_mosi rises; high phase of HALF cycles.
  - clk_mosi falls and the next bit is driven on the same cycle.
  - The first bit therefore has 2*HALF low time.
  - After the 88th high phase, clk_mosi falls and spi_mosi=0.
- HOLD (HALF cycles): cs=0, clk_mosi=0.
- GAP (GAP cycles): cs=1.
  - Then IDLE, with done=1 and ready_out=1 on the same cycle.
- Frame timing, accept at cycle 0:
  - Rising edge k (0..87) at cycle 1+2*HALF+2*HALF*k.
  - ready_out high at cycle 1+HALF+176*HALF+HALF+GAP, i.e. 721 with defaults.
- Exactly 88 rising edges per frame; no clk_mosi edges while cs=1.
- pending flag:
  - Set when a RUN frame reaches GAP.
  - Cleared whenever sync_ready==0 is observed.
  - Prevents a second RUN frame from launching on stale ready. A missed low pulse is resolved by the timeout.
- Bit counter is 7 bits and never wraps past 87. The half-period counter reloads on every phase change.
- done and err are never asserted together.

Decomposition:
- spi_frame_pkg:
  - FRAME_BITS=88.
  - OP_COEF=8'h00, OP_RUN=8'hff.
  - state_t enum: IDLE, WAIT_TGT, SETUP, SHIFT, HOLD, GAP.
- Sub-module spi_sclk_gen: half-period counter producing phase-end ticks and the clk_mosi register. Parameter HALF; input run.
- 2-FF synchroniser is inline.

Test Plan:
- Reset values: pulse rstb low -> ready_out=1, cs=1, clk_mosi=0, spi_mosi=0, done=0, err=0; no clk_mosi toggles for 1000 cycles.
- Coefficient frame: opcode 8'h00, data 80'h0123_4567_89AB_CDEF_1357 at cycle 0 -> first rise at cycle 9; bits sampled on rises equal 88'h00_0123…1357 MSB first; done and ready_out at cycle 721.
- RUN gating: opcode 8'hff, target_ready low, raised at cycle 100 -> cs stays 1 until cycle 103, falls at 103; then the frame proceeds with normal timing.
- Timeout: TGT_TIMEOUT=64, opcode 8'hff, target_ready held low -> err pulse at cycle 65, ready_out=1 at 65, cs never asserted, done never asserted.
- Back-to-back / stale ready: valid_in held high across two RUN frames, target_ready held high throughout -> second frame does not start (pending=1) and times out with err. Repeat with target_ready pulsed low for 4 cycles after frame 1 -> second frame transmits.
- Reset mid-frame: assert rstb during bit 40 -> cs=1, clk_mosi=0 immediately (asynchronous); after release, a new frame transmits correctly from bit 87.
